// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: row-by-row scan, per-frame key pick, press/release debounce FSM.
// Define KEYPAD_ACCUM_EN to build the 32-bit nibble accumulator behind `value`.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  row,
    input  logic [3:0]  col,
    input  logic        value_clr,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_down,
    output logic [31:0] value
);

    localparam int              CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_N   = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

    logic [3:0]       col_meta, col_s;
    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       r;
    logic             tick;
    logic             row_hit;
    logic [1:0]       low_col;
    logic [3:0]       samp_code;
    logic             acc_hit;
    logic [3:0]       acc_code;
    logic             frame_done;
    logic             fd_hit;
    logic [3:0]       fd_code;
    state_t           state;
    logic [3:0]       cand;
    logic [3:0]       cnt;
    logic [3:0]       rel;

    function automatic logic [3:0] key_map(input logic [1:0] rr, input logic [1:0] cc);
        logic [3:0] k;
        case ({rr, cc})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= '0;
            col_s    <= '0;
        end else begin
            col_meta <= col;
            col_s    <= col_meta;
        end
    end

    assign tick = (div_cnt == CNT_MAX);
    assign row  = ~(4'b0001 << r);

    always_comb begin
        row_hit = (col_s != 4'hF);
        low_col = 2'd3;
        if (!col_s[0])      low_col = 2'd0;
        else if (!col_s[1]) low_col = 2'd1;
        else if (!col_s[2]) low_col = 2'd2;
        samp_code = key_map(r, low_col);
    end

    // Scan: sample on the last cycle of each row slot; the first hit of a frame sticks,
    // which makes the lowest row and then the lowest column win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            r          <= 2'd0;
            acc_hit    <= 1'b0;
            acc_code   <= 4'h0;
            frame_done <= 1'b0;
            fd_hit     <= 1'b0;
            fd_code    <= 4'h0;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                div_cnt <= '0;
                r       <= r + 2'd1;
                if (r == 2'd3) begin
                    frame_done <= 1'b1;
                    fd_hit     <= acc_hit | row_hit;
                    fd_code    <= acc_hit ? acc_code : samp_code;
                    acc_hit    <= 1'b0;
                    acc_code   <= 4'h0;
                end else if (!acc_hit && row_hit) begin
                    acc_hit  <= 1'b1;
                    acc_code <= samp_code;
                end
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
        end
    end

    // Debounce FSM, stepped once per completed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= 4'h0;
            cnt       <= 4'h0;
            rel       <= 4'h0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_done) begin
                case (state)
                    IDLE: begin
                        if (fd_hit) begin
                            cand <= fd_code;
                            if (DEB_N == 4'd1) begin
                                state     <= PRESSED;
                                key_valid <= 1'b1;
                                key_code  <= fd_code;
                                key_down  <= 1'b1;
                                rel       <= 4'h0;
                                cnt       <= 4'h0;
                            end else begin
                                state <= DEBOUNCE;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (!fd_hit) begin
                            state <= IDLE;
                            cnt   <= 4'h0;
                        end else if (fd_code == cand) begin
                            if (cnt + 4'd1 == DEB_N) begin
                                state     <= PRESSED;
                                key_valid <= 1'b1;
                                key_code  <= cand;
                                key_down  <= 1'b1;
                                rel       <= 4'h0;
                                cnt       <= 4'h0;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            cand <= fd_code;
                            cnt  <= 4'd1;
                        end
                    end
                    PRESSED: begin
                        if (fd_hit) begin
                            rel <= 4'h0;
                        end else if (rel + 4'd1 == DEB_N) begin
                            state    <= IDLE;
                            key_down <= 1'b0;
                            rel      <= 4'h0;
                        end else begin
                            rel <= rel + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef KEYPAD_ACCUM_EN
    logic [31:0] value_q;

    // Clear takes priority over the shift, but a simultaneous press still lands as the first digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 32'h0;
        end else if (value_clr && key_valid) begin
            value_q <= {28'h0, key_code};
        end else if (value_clr) begin
            value_q <= 32'h0;
        end else if (key_valid) begin
            value_q <= {value_q[27:0], key_code};
        end
    end

    assign value = value_q;
`else
    logic unused_value_clr;
    assign unused_value_clr = value_clr;
    assign value = 32'h0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2) with a physical keypad model.
module tb_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        value_clr;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;
    logic [31:0] value;
    logic [15:0] keys;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;
    int back2back   = 0;
    logic prev_kv   = 1'b0;
    int pulses_before;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col), .value_clr(value_clr),
        .key_valid(key_valid), .key_code(key_code), .key_down(key_down), .value(value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // keys[r*4+c] pressed shorts row r to column c
    always_comb begin
        col = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            if (!row[rr])
                for (int cc = 0; cc < 4; cc++)
                    if (keys[rr*4+cc]) col[cc] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulses++;
            if (prev_kv) back2back++;
        end
        prev_kv = key_valid;
    end

    function automatic logic [31:0] ev(input logic [31:0] v);
`ifdef KEYPAD_ACCUM_EN
        return v;
`else
        return 32'h0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Return on the first negedge after the scan wraps from row 3 to row 0.
    task automatic align();
        int n;
        n = 0;
        while (row !== 4'b0111 && n < 64) begin @(negedge clk); n++; end
        while (row !== 4'b1110 && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) begin
            vectors++;
            miscompares++;
            $error("FAIL align: observed row %b expected wrap to 1110", row);
        end
    endtask

    // From frame start, two matching frames put key_valid high on the 33rd negedge.
    task automatic press_key(input logic [15:0] mask, input logic [3:0] code,
                             input logic [31:0] v_before, input logic [31:0] v_after);
        align();
        keys = mask;
        repeat (32) @(negedge clk);
        chk("kv_early", {31'h0, key_valid}, 32'h0);
        @(negedge clk);
        chk("kv_pulse", {31'h0, key_valid}, 32'h1);
        chk("kv_code", {28'h0, key_code}, {28'h0, code});
        chk("kv_down", {31'h0, key_down}, 32'h1);
        chk("val_hold", value, v_before);
        @(negedge clk);
        chk("kv_end", {31'h0, key_valid}, 32'h0);
        chk("val_upd", value, v_after);
    endtask

    task automatic release_keys();
        keys = 16'h0;
        repeat (52) @(negedge clk);
        chk("rel_down", {31'h0, key_down}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        keys = 16'h0;
        value_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_row", {28'h0, row}, 32'hE);
        chk("rst_kv", {31'h0, key_valid}, 32'h0);
        chk("rst_code", {28'h0, key_code}, 32'h0);
        chk("rst_down", {31'h0, key_down}, 32'h0);
        chk("rst_val", value, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("walk0", {28'h0, row}, 32'hE);
        @(negedge clk);
        chk("walk1", {28'h0, row}, 32'hD);
        repeat (4) @(negedge clk);
        chk("walk2", {28'h0, row}, 32'hB);
        repeat (4) @(negedge clk);
        chk("walk3", {28'h0, row}, 32'h7);
        repeat (4) @(negedge clk);
        chk("walk4", {28'h0, row}, 32'hE);

        // single press of row1/col1
        press_key(16'h0020, 4'h5, ev(32'h0), ev(32'h5));
        repeat (14) @(negedge clk);
        chk("single_down", {31'h0, key_down}, 32'h1);
        release_keys();
        chk("single_count", pulses, 1);

        // bounce: row0/col0 present on alternate frames only
        align();
        for (int i = 0; i < 4; i++) begin
            keys = 16'h0001;
            repeat (16) @(negedge clk);
            keys = 16'h0000;
            repeat (16) @(negedge clk);
        end
        chk("bounce_count", pulses, 1);
        chk("bounce_down", {31'h0, key_down}, 32'h0);
        press_key(16'h0001, 4'h1, ev(32'h5), ev(32'h51));
        release_keys();

        // two keys: row0 wins; extra or changed keys while pressed give no pulse
        press_key(16'h0108, 4'hA, ev(32'h51), ev(32'h51A));
        keys = 16'h0128;
        repeat (48) @(negedge clk);
        keys = 16'h0100;
        repeat (48) @(negedge clk);
        chk("two_count", pulses, 3);
        chk("two_down", {31'h0, key_down}, 32'h1);
        chk("two_code", {28'h0, key_code}, 32'hA);
        release_keys();

        // accumulator
        value_clr = 1'b1;
        @(negedge clk);
        value_clr = 1'b0;
        chk("clr0", value, 32'h0);
        press_key(16'h0001, 4'h1, ev(32'h0), ev(32'h1));
        release_keys();
        press_key(16'h0002, 4'h2, ev(32'h1), ev(32'h12));
        release_keys();
        press_key(16'h0004, 4'h3, ev(32'h12), ev(32'h123));
        release_keys();
        press_key(16'h8000, 4'hD, ev(32'h123), ev(32'h123D));
        release_keys();
        chk("acc_123D", value, ev(32'h0000123D));
        align();
        keys = 16'h0100;
        repeat (33) @(negedge clk);
        chk("clr_kv", {31'h0, key_valid}, 32'h1);
        chk("clr_code", {28'h0, key_code}, 32'h7);
        value_clr = 1'b1;
        @(negedge clk);
        value_clr = 1'b0;
        chk("clr_with_kv", value, ev(32'h7));
        release_keys();
        value_clr = 1'b1;
        @(negedge clk);
        value_clr = 1'b0;
        chk("clr_alone", value, 32'h0);

        // reset during debounce, then a fresh debounce
        align();
        keys = 16'h0020;
        repeat (20) @(negedge clk);
        pulses_before = pulses;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_row", {28'h0, row}, 32'hE);
        chk("mid_rst_kv", {31'h0, key_valid}, 32'h0);
        chk("mid_rst_code", {28'h0, key_code}, 32'h0);
        chk("mid_rst_down", {31'h0, key_down}, 32'h0);
        chk("mid_rst_val", value, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (32) @(negedge clk);
        chk("mid_no_kv", {31'h0, key_valid}, 32'h0);
        chk("mid_count", pulses, pulses_before);
        @(negedge clk);
        chk("mid_kv", {31'h0, key_valid}, 32'h1);
        chk("mid_code", {28'h0, key_code}, 32'h5);
        release_keys();

        chk("total_pulses", pulses, 9);
        chk("back2back", back2back, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
